mat_stream_ctrl: RTL and testbench

Read-side sequencer that streams a WIDTH×HEIGHT matrix tile out of on-chip buffer memory in row-major order. It drives a fixed-latency memory read port and feeds a valid/ready output stream toward the AIE PLIO interface. Row-end and tile-end markers are carried through the read pipeline. An internal credit scheme guarantees no beat is ever dropped under downstream backpressure.

---
 rtl/mat_stream_pkg.sv | 16 +
 rtl/ms_fifo.sv | 64 ++++++
 rtl/mat_stream_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mat_stream_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_stream_pkg.sv
// Shared types for the matrix tile read sequencer: FSM states and the per-beat tag
// that travels alongside each memory read.
package mat_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } ms_state_t;

  typedef struct packed {
    logic last;
    logic eot;
  } ms_tag_t;

endpackage

// File: rtl/ms_fifo.sv
// Synchronous FIFO with an occupancy count. Empty reads present zero so the stream
// outputs stay at their idle values. Push and pop may happen together even when full.
module ms_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         valid_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != DepthCnt) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/mat_stream_ctrl.sv
// Streams a WIDTH x HEIGHT tile out of buffer memory in row-major order, carrying
// row/tile end markers through the read latency and throttling reads by FIFO credit.
module mat_stream_ctrl
  import mat_stream_pkg::*;
#(
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] WIDTH,
  input  logic [MATRIXSIZE_W-1:0] HEIGHT,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_last,
  output logic                    m_eot
);

  localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(FIFO_DEPTH);

  ms_state_t               state_q, state_d;
  logic [MATRIXSIZE_W-1:0] width_q, width_d, height_q, height_d;
  logic [MATRIXSIZE_W-1:0] pixel_q, pixel_d, slice_q, slice_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    done_q, done_d;
  logic [CntW-1:0]         inflight_q, inflight_d, fifo_count;
  ms_tag_t                 tag_q [RD_LAT];
  ms_tag_t                 tag_d [RD_LAT];
  logic [RD_LAT-1:0]       tag_vld_q, tag_vld_d;
  logic                    credit_ok, issue, is_last, is_eot, tag_push, eot_hs;
  logic [DATA_W+1:0]       fifo_rdata;
  ms_tag_t                 out_tag;

  // Reads in flight plus beats already buffered never exceed the FIFO depth.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CreditMax;
  assign issue     = (state_q == StRun) && credit_ok;
  assign is_last   = (pixel_q == width_q - MATRIXSIZE_W'(1));
  assign is_eot    = is_last && (slice_q == height_q - MATRIXSIZE_W'(1));
  assign tag_push  = tag_vld_q[RD_LAT-1];
  assign eot_hs    = m_valid && m_ready && m_eot;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    pixel_d  = pixel_q;
    slice_d  = slice_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if ((WIDTH == '0) || (HEIGHT == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d  = StRun;
            width_d  = WIDTH;
            height_d = HEIGHT;
            addr_d   = base_addr;
            pixel_d  = '0;
            slice_d  = '0;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          if (is_last) begin
            pixel_d = '0;
            slice_d = slice_q + MATRIXSIZE_W'(1);
          end else begin
            pixel_d = pixel_q + MATRIXSIZE_W'(1);
          end
          if (is_eot) state_d = StDrain;
        end
      end
      StDrain: begin
        if (eot_hs) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_d[0].last = is_last;
    tag_d[0].eot  = is_eot;
    tag_vld_d[0]  = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i]     = tag_q[i-1];
      tag_vld_d[i] = tag_vld_q[i-1];
    end
    case ({issue, tag_push})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      pixel_q    <= '0;
      slice_q    <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      inflight_q <= '0;
      tag_q      <= '{default: '0};
      tag_vld_q  <= '0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      pixel_q    <= pixel_d;
      slice_q    <= slice_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      tag_vld_q  <= tag_vld_d;
    end
  end

  ms_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_W + 2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tag_push),
    .wdata_i ({rd_data, tag_q[RD_LAT-1]}),
    .pop_i   (m_ready),
    .rdata_o (fifo_rdata),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

  assign {m_data, out_tag} = fifo_rdata;
  assign m_last  = out_tag.last;
  assign m_eot   = out_tag.eot;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign rd_en   = issue;
  assign rd_addr = addr_q;

endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Self-checking bench for mat_stream_ctrl: a latency-accurate memory model feeds the DUT,
// and expected beats queued at start time are compared against each output handshake.
module tb_mat_stream_ctrl;

  localparam int unsigned MW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;
  localparam int unsigned RL = 2;
  localparam int unsigned FD = RL + 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          eot;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] WIDTH, HEIGHT;
  logic [AW-1:0] base_addr;
  logic          busy, done, rd_en, m_valid, m_ready, m_last, m_eot;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  mat_stream_ctrl #(
    .MATRIXSIZE_W (MW),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .RD_LAT       (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_eot     (m_eot)
  );

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    return {4{a ^ 16'h3c3c, a}};
  endfunction

  // Fixed-latency memory: data for an address read in cycle t is presented in cycle t+RL.
  logic [DW-1:0] mem_pipe [RL];
  always @(posedge clk) begin
    mem_pipe[0] <= rd_en ? mk_data(rd_addr) : '0;
    for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign rd_data = mem_pipe[RL-1];

  task automatic push_expected(input logic [AW-1:0] base, input int w, input int h);
    beat_t b;
    for (int s = 0; s < h; s++) begin
      for (int p = 0; p < w; p++) begin
        b.data = mk_data(AW'(base + AW'(s * w + p)));
        b.last = (p == w - 1);
        b.eot  = (p == w - 1) && (s == h - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Leaves the bench at #1 into cycle 1, where cycle 0 holds the start pulse.
  task automatic kick(input int w, input int h, input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    start     = 1'b1;
    WIDTH     = MW'(w);
    HEIGHT    = MW'(h);
    base_addr = base;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; WIDTH = '0; HEIGHT = '0; base_addr = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({busy, done, rd_en, m_valid, m_last, m_eot} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got busy/done/rd_en/valid/last/eot=%b want 000000",
               {busy, done, rd_en, m_valid, m_last, m_eot});
    end
    n_assert++;
    if (rd_addr !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rd_addr=%h m_data=%h want 0/0", rd_addr, m_data);
    end
  endtask

  task automatic test_basic();
    beat_t e;
    logic [3:0] exp_ctl;
    m_ready = 1'b1;
    push_expected(16'h0010, 3, 2);
    kick(3, 2, 16'h0010);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_ctl = {(k <= 9), (k == 10), (k <= 6), (k >= 4 && k <= 9)};
      n_assert++;
      if ({busy, done, rd_en, m_valid} !== exp_ctl) begin
        n_fail++;
        $display("FAIL basic_ctl cycle %0d: got busy/done/rd_en/valid=%b want %b",
                 k, {busy, done, rd_en, m_valid}, exp_ctl);
      end
      if (rd_en) begin
        n_assert++;
        if (rd_addr !== AW'(16'h0010 + k - 1)) begin
          n_fail++;
          $display("FAIL basic_addr cycle %0d: got %h want %h", k, rd_addr, AW'(16'h0010 + k - 1));
        end
      end
      if (m_valid && m_ready) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL basic_beat: got unexpected beat %h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last, m_eot} !== e) begin
            n_fail++;
            $display("FAIL basic_beat cycle %0d: got %h/%b/%b want %h/%b/%b",
                     k, m_data, m_last, m_eot, e.data, e.last, e.eot);
          end
        end
      end
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_count: got %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_zero();
    m_ready = 1'b1;
    kick(0, 5, 16'h0080);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_assert++;
      if ({busy, done, rd_en, m_valid} !== {1'b0, (k == 1), 2'b00}) begin
        n_fail++;
        $display("FAIL zero_dim cycle %0d: got busy/done/rd_en/valid=%b want %b",
                 k, {busy, done, rd_en, m_valid}, {1'b0, (k == 1), 2'b00});
      end
    end
  endtask

  task automatic test_random_ready();
    beat_t e, prev;
    logic  prev_stall = 1'b0;
    logic  seen_done  = 1'b0;
    int    beats = 0;
    int    issued = 0;
    int    k = 1;
    m_ready = 1'b0;
    push_expected(16'h0200, 4, 4);
    kick(4, 4, 16'h0200);
    while (!seen_done && k < 400) begin
      @(negedge clk);
      if (rd_en) issued++;
      if (k == 8) begin
        n_assert++;
        if (issued != FD) begin
          n_fail++;
          $display("FAIL rand_credit_stall: got %0d issues under backpressure want %0d", issued, FD);
        end
      end
      if (prev_stall) begin
        n_assert++;
        if ({m_valid, m_data, m_last, m_eot} !== {1'b1, prev}) begin
          n_fail++;
          $display("FAIL rand_hold cycle %0d: got %b/%h/%b/%b want 1/%h/%b/%b", k,
                   m_valid, m_data, m_last, m_eot, prev.data, prev.last, prev.eot);
        end
      end
      n_assert++;
      if (dut.u_fifo.count_o > FD ||
          (dut.u_fifo.push_i && dut.u_fifo.count_o == FD && !dut.u_fifo.pop_i)) begin
        n_fail++;
        $display("FAIL rand_overflow cycle %0d: got count=%0d push=%b pop=%b want no overflow",
                 k, dut.u_fifo.count_o, dut.u_fifo.push_i, dut.u_fifo.pop_i);
      end
      if (m_valid && m_ready) begin
        beats++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_beat: got unexpected beat %h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last, m_eot} !== e) begin
            n_fail++;
            $display("FAIL rand_beat %0d: got %h/%b/%b want %h/%b/%b",
                     beats, m_data, m_last, m_eot, e.data, e.last, e.eot);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev       = '{data: m_data, last: m_last, eot: m_eot};
      seen_done  = done;
      k++;
      @(posedge clk);
      #1;
      m_ready = (k <= 8) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    n_assert++;
    if (!seen_done || beats != 16 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_complete: got done=%b beats=%0d left=%0d want 1/16/0",
               seen_done, beats, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_ignore_start();
    beat_t e;
    int    beats = 0;
    m_ready = 1'b1;
    push_expected(16'h0040, 3, 2);
    kick(3, 2, 16'h0040);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_assert++;
      if (done !== (k == 10)) begin
        n_fail++;
        $display("FAIL ignore_done cycle %0d: got %b want %b", k, done, (k == 10));
      end
      if (m_valid && m_ready) begin
        beats++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ignore_beat: got unexpected beat %h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last, m_eot} !== e) begin
            n_fail++;
            $display("FAIL ignore_beat %0d: got %h/%b/%b want %h/%b/%b",
                     beats, m_data, m_last, m_eot, e.data, e.last, e.eot);
          end
        end
      end
      @(posedge clk);
      #1;
      start = (k + 1 == 3);
      if (k + 1 == 3) begin
        WIDTH = MW'(9); HEIGHT = MW'(9); base_addr = 16'h0099;
      end
    end
    n_assert++;
    if (beats != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignore_count: got %0d beats want 6", beats);
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    beat_t e;
    int    beats = 0;
    int    k = 0;
    m_ready = 1'b1;
    push_expected(16'h0300, 4, 3);
    kick(4, 3, 16'h0300);
    while (beats < 5 && k < 40) begin
      @(negedge clk);
      k++;
      if (m_valid && m_ready) begin
        beats++;
        e = exp_q.pop_front();
        n_assert++;
        if ({m_data, m_last, m_eot} !== e) begin
          n_fail++;
          $display("FAIL rst_pre_beat %0d: got %h want %h", beats, m_data, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_assert++;
      if ({busy, done, rd_en, m_valid, m_last, m_eot} !== 6'b0 || m_data !== '0) begin
        n_fail++;
        $display("FAIL rst_mid cycle %0d: got busy/done/rd_en/valid/last/eot=%b data=%h want 0",
                 c, {busy, done, rd_en, m_valid, m_last, m_eot}, m_data);
      end
    end
    m_ready = 1'b1;
    beats = 0;
    push_expected(16'h0500, 2, 1);
    kick(2, 1, 16'h0500);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        beats++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rst_post_beat: got unexpected beat %h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last, m_eot} !== e) begin
            n_fail++;
            $display("FAIL rst_post_beat %0d: got %h/%b/%b want %h/%b/%b",
                     beats, m_data, m_last, m_eot, e.data, e.last, e.eot);
          end
        end
      end
    end
    n_assert++;
    if (beats != 2) begin
      n_fail++;
      $display("FAIL rst_post_count: got %0d beats want 2", beats);
    end
    exp_q.delete();
  endtask

  task automatic test_addr_wrap();
    beat_t e;
    int    issued = 0;
    m_ready = 1'b1;
    push_expected(16'hFFFE, 1, 3);
    kick(1, 3, 16'hFFFE);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rd_en) begin
        n_assert++;
        if (rd_addr !== AW'(16'hFFFE + issued)) begin
          n_fail++;
          $display("FAIL wrap_addr %0d: got %h want %h", issued, rd_addr, AW'(16'hFFFE + issued));
        end
        issued++;
      end
      if (m_valid && m_ready) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_beat: got unexpected beat %h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last, m_eot} !== e) begin
            n_fail++;
            $display("FAIL wrap_beat: got %h/%b/%b want %h/%b/%b",
                     m_data, m_last, m_eot, e.data, e.last, e.eot);
          end
        end
      end
    end
    n_assert++;
    if (issued != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_count: got issued=%0d left=%0d want 3/0", issued, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_random_ready();
    test_ignore_start();
    test_mid_reset();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
